// File: rtl/running_enemy_anim_ctrl_if.sv
// -----------------------------------------------------------------------------
// running_enemy_anim_ctrl_if
//   Bundles the scan/position inputs, the sprite-ROM handshake and the
//   palette-side outputs of the running enemy sprite sequencer.
//   master : video/system side (drives scan, position, control and rom_data)
//   slave  : the sequencer (drives rom_addr, pal_index, pix_valid, frame_sel)
// -----------------------------------------------------------------------------
interface running_enemy_anim_ctrl_if #(
   parameter int ADDR_W = 13
);
   logic              frame_start;
   logic              run_en;
   logic              face_left;
   logic [9:0]        pos_x;
   logic [9:0]        pos_y;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_data;
   logic [2:0]        pal_index;
   logic              pix_valid;
   logic [2:0]        frame_sel;

   modport master (
      output frame_start, run_en, face_left, pos_x, pos_y, DrawX, DrawY, rom_data,
      input  rom_addr, pal_index, pix_valid, frame_sel
   );

   modport slave (
      input  frame_start, run_en, face_left, pos_x, pos_y, DrawX, DrawY, rom_data,
      output rom_addr, pal_index, pix_valid, frame_sel
   );
endinterface

// File: rtl/running_enemy_anim_ctrl.sv
// -----------------------------------------------------------------------------
// running_enemy_anim_ctrl
//   Run-cycle sequencer for the green enemy sprite. Steps the animation frame
//   every FRAME_DIV video frames while running, maps (DrawX, DrawY) to a
//   sprite-ROM address and returns the ROM palette index with an opacity
//   valid, two clocks after the scan position.
// Ports
//   Clk      : pixel clock
//   Reset_n  : asynchronous reset, active low
//   bus      : slave side of running_enemy_anim_ctrl_if
//              in : frame_start, run_en, face_left, pos_x/y, DrawX/Y, rom_data
//              out: rom_addr, pal_index, pix_valid, frame_sel
// -----------------------------------------------------------------------------
module running_enemy_anim_ctrl #(
   parameter int SPR_W      = 24,
   parameter int SPR_H      = 40,
   parameter int NUM_FRAMES = 6,
   parameter int FRAME_DIV  = 6,
   parameter int ADDR_W     = 13
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   running_enemy_anim_ctrl_if.slave bus
);

   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   typedef enum logic [1:0] {
      ST_STAND = 2'd0,
      ST_RUN   = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        frame_q, frame_d;
   logic [DIV_W-1:0]  div_q,   div_d;

   // Shadow copies so the picture never changes mid-frame.
   logic              mir_q;
   logic [9:0]        px_q, py_q;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              v1_q;
   logic [2:0]        pal_q;
   logic              pv_q;

   logic              in_box;
   logic [10:0]       dx, dy, px, py;
   logic [9:0]        col, row;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_STAND;
         frame_q <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         div_q   <= div_d;
      end
   end

   // Only evaluated on frame_start so the frame cannot change mid-scan.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      div_d   = div_q;
      if (bus.frame_start) begin
         case (state_q)
            ST_STAND: begin
               frame_d = '0;
               div_d   = '0;
               if (bus.run_en) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!bus.run_en) begin
                  state_d = ST_STOP;
               end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                  div_d   = '0;
                  frame_d = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            ST_STOP: begin
               frame_d = '0;
               div_d   = '0;
               state_d = bus.run_en ? ST_RUN : ST_STAND;
            end
            default: begin
               state_d = ST_STAND;
               frame_d = '0;
               div_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------ shadow latches
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mir_q <= 1'b0;
         px_q  <= '0;
         py_q  <= '0;
      end else if (bus.frame_start) begin
         mir_q <= bus.face_left;
         px_q  <= bus.pos_x;
         py_q  <= bus.pos_y;
      end
   end

   // ------------------------------------------------- stage 0: addressing
   // 11-bit compare keeps px+SPR_W past 1023 from wrapping onto X=0.
   always_comb begin
      dx     = {1'b0, bus.DrawX};
      dy     = {1'b0, bus.DrawY};
      px     = {1'b0, px_q};
      py     = {1'b0, py_q};
      in_box = (dx >= px) && (dx < px + 11'(SPR_W)) &&
               (dy >= py) && (dy < py + 11'(SPR_H));
      col    = bus.DrawX - px_q;
      row    = bus.DrawY - py_q;
      if (mir_q) col = 10'(SPR_W - 1) - col;
      addr_d = '0;
      if (in_box)
         addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) +
                  ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
   end

   // rom_addr is itself the ROM's address register: data returns one clock
   // later, lined up with v1_q, and is registered into pal_index.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q <= '0;
         v1_q   <= 1'b0;
         pal_q  <= '0;
         pv_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         v1_q   <= in_box;
         pal_q  <= v1_q ? bus.rom_data : 3'd0;
         pv_q   <= v1_q && (bus.rom_data != 3'd0);
      end
   end

   assign bus.rom_addr  = addr_q;
   assign bus.pal_index = pal_q;
   assign bus.pix_valid = pv_q;
   assign bus.frame_sel = frame_q;

endmodule

// File: tb/tb_running_enemy_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_running_enemy_anim_ctrl
//   Randomised scoreboard bench. The driver pushes expected rom_addr (due one
//   clock later) and pal_index/pix_valid (due two clocks later) computed from
//   a behavioural model; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_running_enemy_anim_ctrl;
   localparam int SPR_W = 24;
   localparam int SPR_H = 40;
   localparam int NF    = 6;
   localparam int FD    = 6;
   localparam int AW    = 13;
   localparam int ROM_N = NF * SPR_W * SPR_H;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   running_enemy_anim_ctrl_if #(.ADDR_W(AW)) bus ();

   running_enemy_anim_ctrl #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_DIV(FD), .ADDR_W(AW)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   // Sprite ROM contents; the DUT's registered rom_addr is the read address.
   logic [2:0] mem [0:ROM_N-1];
   assign bus.rom_data = (int'(bus.rom_addr) < ROM_N) ? mem[bus.rom_addr] : 3'd0;

   typedef struct {
      int due;
      int a;
      int p;
      bit v;
   } exp_t;
   exp_t qa[$];
   exp_t qp[$];

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------- reference model
   int m_px, m_py, m_phase, m_cnt, m_frame;  // phase: 0 standing, 1 running, 2 settling
   bit m_mir;

   function automatic void model_reset();
      m_px = 0; m_py = 0; m_mir = 0;
      m_phase = 0; m_cnt = 0; m_frame = 0;
   endfunction

   // Running frame = number of run-steps taken, divided down and wrapped.
   function automatic void model_pulse(input bit run);
      case (m_phase)
         0: begin
            m_frame = 0;
            if (run) begin m_phase = 1; m_cnt = 0; end
         end
         1: begin
            if (!run) m_phase = 2;
            else begin
               m_cnt++;
               m_frame = (m_cnt / FD) % NF;
            end
         end
         default: begin
            m_frame = 0;
            m_cnt   = 0;
            m_phase = run ? 1 : 0;
         end
      endcase
   endfunction

   function automatic void expect_pix(input int x, input int y,
                                      output int a, output int p, output bit v);
      bit inb;
      int col, row;
      inb = (x >= m_px) && (x < m_px + SPR_W) && (y >= m_py) && (y < m_py + SPR_H);
      col = x - m_px;
      row = y - m_py;
      if (m_mir) col = SPR_W - 1 - col;
      a = inb ? (m_frame * SPR_W * SPR_H + row * SPR_W + col) : 0;
      p = inb ? int'(mem[a]) : 0;
      v = (p != 0);
   endfunction

   // --------------------------------------------------------- driver
   task automatic step(input bit fs, input int x, input int y);
      int a, p;
      bit v;
      @(negedge Clk);
      bus.frame_start = fs;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      expect_pix(x, y, a, p, v);
      qa.push_back('{due: cyc + 1, a: a, p: 0, v: 1'b0});
      qp.push_back('{due: cyc + 2, a: 0, p: p, v: v});
      if (fs) begin
         model_pulse(bus.run_en);
         m_px  = int'(bus.pos_x);
         m_py  = int'(bus.pos_y);
         m_mir = bus.face_left;
      end
      @(posedge Clk);
      #1 chk("frame_sel", int'(bus.frame_sel), m_frame);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      bus.frame_start = 1'b0;
      Reset_n = 1'b0;
      qa.delete();
      qp.delete();
      #1;
      chk("rst_pix_valid", int'(bus.pix_valid), 0);
      chk("rst_pal_index", int'(bus.pal_index), 0);
      chk("rst_frame_sel", int'(bus.frame_sel), 0);
      chk("rst_rom_addr",  int'(bus.rom_addr), 0);
      model_reset();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   function automatic int rand_near_x();
      int x;
      if ($urandom_range(0, 9) < 7) x = m_px + int'($urandom_range(0, SPR_W + 3)) - 2;
      else x = int'($urandom_range(0, 1023));
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      return x;
   endfunction

   function automatic int rand_near_y();
      int y;
      if ($urandom_range(0, 9) < 7) y = m_py + int'($urandom_range(0, SPR_H + 3)) - 2;
      else y = int'($urandom_range(0, 1023));
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      return y;
   endfunction

   task automatic rand_steps(input int n);
      for (int i = 0; i < n; i++) begin
         bit fs;
         fs = ($urandom_range(0, 19) == 0);
         if (fs && $urandom_range(0, 3) == 0) bus.run_en = ~bus.run_en;
         // Position and mirror move freely mid-frame; only frame_start latches them.
         if ($urandom_range(0, 7) == 0) begin
            bus.pos_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(995, 1023))
                                                    : 10'($urandom_range(0, 1023));
            bus.pos_y = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(995, 1023))
                                                    : 10'($urandom_range(0, 1023));
            bus.face_left = 1'($urandom_range(0, 1));
         end
         step(fs, rand_near_x(), rand_near_y());
      end
   endtask

   // --------------------------------------------------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (Reset_n) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
               e = qa.pop_front();
               chk("sb_rom_addr", int'(bus.rom_addr), e.a);
            end
            if (qp.size() > 0 && qp[0].due == cyc) begin
               e = qp.pop_front();
               chk("sb_pal_index", int'(bus.pal_index), e.p);
               chk("sb_pix_valid", int'(bus.pix_valid), int'(e.v));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   // --------------------------------------------------------- stimulus
   initial begin
      for (int i = 0; i < ROM_N; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.frame_start = 1'b0;
      bus.run_en      = 1'b0;
      bus.face_left   = 1'b0;
      bus.pos_x       = 10'd100;
      bus.pos_y       = 10'd50;
      bus.DrawX       = 10'd105;
      bus.DrawY       = 10'd60;
      model_reset();
      do_reset();

      // Enter RUN, then 12 run-steps -> frame 2 with pos (100,50) latched.
      bus.run_en = 1'b1;
      for (int k = 0; k < 13; k++) begin
         step(1'b1, rand_near_x(), rand_near_y());
         step(1'b0, rand_near_x(), rand_near_y());
      end
      chk("frame_after_12", int'(bus.frame_sel), 2);
      step(1'b0, 105, 60);
      chk("addr_nomirror", int'(bus.rom_addr), 2165);
      bus.face_left = 1'b1;
      step(1'b1, 0, 0);
      step(1'b0, 105, 60);
      chk("addr_mirror", int'(bus.rom_addr), 2178);

      // Box edges.
      step(1'b0, 123, 60);
      step(1'b0, 124, 60);
      step(1'b0, 100, 89);
      step(1'b0, 100, 90);
      step(1'b0, 99, 60);
      step(1'b0, 100, 49);

      // Finish 36 run-steps: frame wraps back to 0.
      for (int k = 13; k < 36; k++) begin
         step(1'b1, rand_near_x(), rand_near_y());
         step(1'b0, rand_near_x(), rand_near_y());
      end
      chk("frame_wrap", int'(bus.frame_sel), 0);
      for (int k = 0; k < 6; k++) step(1'b1, rand_near_x(), rand_near_y());
      chk("frame_after_42", int'(bus.frame_sel), 1);

      // Drop run_en: settle one frame, then stand at frame 0.
      bus.run_en = 1'b0;
      step(1'b1, 110, 70);
      step(1'b0, 110, 70);
      step(1'b1, 110, 70);
      chk("stand_frame", int'(bus.frame_sel), 0);

      // Sprite hanging off the right edge must not wrap to X=0.
      bus.pos_x = 10'd1010;
      bus.face_left = 1'b0;
      step(1'b1, 0, 60);
      for (int x = 0; x < 12; x++) step(1'b0, x, 60);
      for (int x = 1008; x < 1024; x++) step(1'b0, x, 60);

      // Transparency: index 0 then 5, exactly two clocks after DrawX.
      bus.pos_x = 10'd100;
      mem[245] = 3'd0;
      mem[246] = 3'd5;
      step(1'b1, 0, 0);
      step(1'b0, 105, 60);
      step(1'b0, 106, 60);
      chk("transp_valid0", int'(bus.pix_valid), 0);
      @(posedge Clk);
      #1;
      chk("transp_valid1", int'(bus.pix_valid), 1);
      chk("transp_index5", int'(bus.pal_index), 5);

      // Randomised traffic, a reset mid-pipeline, more traffic.
      rand_steps(1500);
      bus.run_en = 1'b1;
      bus.pos_x = 10'd200;
      bus.pos_y = 10'd200;
      step(1'b1, 0, 0);
      step(1'b0, 205, 210);
      step(1'b0, 206, 210);
      do_reset();
      step(1'b0, 5, 5);
      chk("post_rst_valid", int'(bus.pix_valid), 0);
      rand_steps(1500);

      repeat (4) @(negedge Clk);
      chk("sb_drain_addr", qa.size(), 0);
      chk("sb_drain_pix", qp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
